// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: bus widths, d_to_e_bus field
// offsets, RV32I opcodes, ALU/memory-size encodings and immediate helpers.
package decode_pkg;

    // Fetch-to-decode and decode-to-execute bus widths
    localparam int F_TO_D_BUS_WD = 64;
    localparam int D_TO_E_BUS_WD = 151;

    // d_to_e_bus field LSB offsets
    localparam int BUS_PC_LSB       = 119;
    localparam int BUS_IMM_LSB      = 87;
    localparam int BUS_RS1_LSB      = 55;
    localparam int BUS_RS2_LSB      = 23;
    localparam int BUS_RD_LSB       = 18;
    localparam int BUS_RD_WE        = 17;
    localparam int BUS_ALU_OP_LSB   = 13;
    localparam int BUS_SRC1_IS_PC   = 12;
    localparam int BUS_SRC2_IS_IMM  = 11;
    localparam int BUS_MEM_RE       = 10;
    localparam int BUS_MEM_WE       = 9;
    localparam int BUS_MEM_SIZE_LSB = 7;
    localparam int BUS_MEM_UNSIGNED = 6;
    localparam int BUS_BR_TYPE_LSB  = 3;
    localparam int BUS_IS_JAL       = 2;
    localparam int BUS_IS_JALR      = 1;
    localparam int BUS_ILLEGAL      = 0;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    // ALU operation codes carried to execute
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;
    localparam logic [3:0] ALU_OP_LUI  = 4'd10;

    // Memory access sizes (match funct3[1:0] of loads/stores)
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    // I-format immediate
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // S-format immediate
    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    // B-format immediate, bit 0 always zero
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // U-format immediate
    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

    // J-format immediate, bit 0 always zero
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // ALU op for OP / OP-IMM; alt selects SUB/SRA where the encoding allows it
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'd0:    op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'd1:    op = ALU_OP_SLL;
            3'd2:    op = ALU_OP_SLT;
            3'd3:    op = ALU_OP_SLTU;
            3'd4:    op = ALU_OP_XOR;
            3'd5:    op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'd6:    op = ALU_OP_OR;
            3'd7:    op = ALU_OP_AND;
            default: op = ALU_OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, and write-through so a same-cycle
// writeback is visible to the instruction being decoded.
module decode_regfile
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_r [32];

    // Register array: cleared on reset, x0 never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read port 1 with x0 forcing and writeback bypass
    always_comb begin
        if (raddr1 == 5'd0) begin
            rdata1 = 32'h0000_0000;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs_r[raddr1];
        end
    end

    // Read port 2 with x0 forcing and writeback bypass
    always_comb begin
        if (raddr2 == 5'd0) begin
            rdata2 = 32'h0000_0000;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs_r[raddr2];
        end
    end

endmodule

// File: rtl/decode.sv
// Decode stage of the 5-stage RV32I pipeline. Holds one instruction from
// fetch, decodes it, reads its operands and issues it to execute once no
// older in-flight instruction still owes it a source register.
module decode
    import decode_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid_i,
    input  logic [F_TO_D_BUS_WD-1:0] f_to_d_bus,
    output logic                     stall_fetch,
    input  logic                     bj_taken_i,
    input  logic                     e_allowin_i,
    input  logic [4:0]               exe_dest_i,
    input  logic [4:0]               mem_dest_i,
    input  logic                     wb_we_i,
    input  logic [4:0]               wb_waddr_i,
    input  logic [31:0]              wb_wdata_i,
    output logic                     d_valid_o,
    output logic [D_TO_E_BUS_WD-1:0] d_to_e_bus
);

    logic        d_valid_r;
    logic [31:0] d_pc_r;
    logic [31:0] d_inst_r;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  funct7_s;

    logic [31:0] imm_val_s;
    logic [3:0]  alu_op_s;
    logic        src1_is_pc_s;
    logic        src2_is_imm_s;
    logic        mem_re_raw_s;
    logic        mem_we_raw_s;
    logic [1:0]  mem_size_s;
    logic        mem_unsigned_s;
    logic [2:0]  br_type_s;
    logic        is_jal_s;
    logic        is_jalr_s;
    logic        illegal_s;
    logic        writes_rd_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        rd_we_s;
    logic        mem_re_s;
    logic        mem_we_s;

    logic [31:0] rs1_data_s;
    logic [31:0] rs2_data_s;
    logic        rs1_hit_s;
    logic        rs2_hit_s;
    logic        hazard_s;
    logic        d_ready_s;
    logic        d_allowin_s;

    assign opcode_s = d_inst_r[6:0];
    assign rd_s     = d_inst_r[11:7];
    assign funct3_s = d_inst_r[14:12];
    assign rs1_s    = d_inst_r[19:15];
    assign rs2_s    = d_inst_r[24:20];
    assign funct7_s = d_inst_r[31:25];

    // Decode register: flush beats load, load only when the slot frees up
    always_ff @(posedge clk) begin
        if (reset) begin
            d_valid_r <= 1'b0;
            d_pc_r    <= RESET_PC;
            d_inst_r  <= 32'h0000_0000;
        end else if (bj_taken_i) begin
            d_valid_r <= 1'b0;
        end else if (d_allowin_s) begin
            d_valid_r <= fetch_valid_i;
            d_pc_r    <= f_to_d_bus[63:32];
            d_inst_r  <= f_to_d_bus[31:0];
        end else begin
            d_valid_r <= d_valid_r;
        end
    end

    // Instruction decode: immediates, control fields and legality
    always_comb begin
        imm_val_s      = 32'h0000_0000;
        alu_op_s       = ALU_OP_ADD;
        src1_is_pc_s   = 1'b0;
        src2_is_imm_s  = 1'b0;
        mem_re_raw_s   = 1'b0;
        mem_we_raw_s   = 1'b0;
        mem_size_s     = MEM_SIZE_B;
        mem_unsigned_s = 1'b0;
        br_type_s      = 3'd0;
        is_jal_s       = 1'b0;
        is_jalr_s      = 1'b0;
        illegal_s      = 1'b0;
        writes_rd_s    = 1'b0;
        use_rs1_s      = 1'b0;
        use_rs2_s      = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                imm_val_s     = imm_u(d_inst_r);
                alu_op_s      = ALU_OP_LUI;
                src2_is_imm_s = 1'b1;
                writes_rd_s   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_val_s     = imm_u(d_inst_r);
                src1_is_pc_s  = 1'b1;
                src2_is_imm_s = 1'b1;
                writes_rd_s   = 1'b1;
            end
            OPC_JAL: begin
                imm_val_s     = imm_j(d_inst_r);
                src1_is_pc_s  = 1'b1;
                src2_is_imm_s = 1'b1;
                is_jal_s      = 1'b1;
                writes_rd_s   = 1'b1;
            end
            OPC_JALR: begin
                imm_val_s     = imm_i(d_inst_r);
                src2_is_imm_s = 1'b1;
                is_jalr_s     = 1'b1;
                writes_rd_s   = 1'b1;
                use_rs1_s     = 1'b1;
                illegal_s     = (funct3_s != 3'd0);
            end
            OPC_BRANCH: begin
                imm_val_s = imm_b(d_inst_r);
                br_type_s = funct3_s;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                illegal_s = (funct3_s[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                imm_val_s      = imm_i(d_inst_r);
                src2_is_imm_s  = 1'b1;
                mem_re_raw_s   = 1'b1;
                mem_size_s     = funct3_s[1:0];
                mem_unsigned_s = funct3_s[2];
                writes_rd_s    = 1'b1;
                use_rs1_s      = 1'b1;
                illegal_s      = (funct3_s[1:0] == 2'b11) || (funct3_s[2] && funct3_s[1]);
            end
            OPC_STORE: begin
                imm_val_s     = imm_s(d_inst_r);
                src2_is_imm_s = 1'b1;
                mem_we_raw_s  = 1'b1;
                mem_size_s    = funct3_s[1:0];
                use_rs1_s     = 1'b1;
                use_rs2_s     = 1'b1;
                illegal_s     = funct3_s[2] || (funct3_s[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                imm_val_s     = imm_i(d_inst_r);
                src2_is_imm_s = 1'b1;
                writes_rd_s   = 1'b1;
                use_rs1_s     = 1'b1;
                alu_op_s      = alu_from_funct3(funct3_s, (funct3_s == 3'd5) && funct7_s[5]);
                if (funct3_s == 3'd1) begin
                    illegal_s = (funct7_s != 7'b0000000);
                end else if (funct3_s == 3'd5) begin
                    illegal_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_OP: begin
                writes_rd_s = 1'b1;
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                alu_op_s    = alu_from_funct3(funct3_s, funct7_s[5]);
                if (funct7_s == 7'b0000000) begin
                    illegal_s = 1'b0;
                end else if (funct7_s == 7'b0100000) begin
                    illegal_s = (funct3_s != 3'd0) && (funct3_s != 3'd5);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE has no effect on an in-order single-issue core
                illegal_s = 1'b0;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Side effects are suppressed for illegal encodings and x0 destinations
    assign rd_we_s  = writes_rd_s && !illegal_s && (rd_s != 5'd0);
    assign mem_re_s = mem_re_raw_s && !illegal_s;
    assign mem_we_s = mem_we_raw_s && !illegal_s;

    decode_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (rs1_data_s),
        .rdata2 (rs2_data_s),
        .we     (wb_we_i),
        .waddr  (wb_waddr_i),
        .wdata  (wb_wdata_i)
    );

    // RAW interlock against execute and memory; writeback is bypassed in the regfile
    assign rs1_hit_s = use_rs1_s && (rs1_s != 5'd0) && ((rs1_s == exe_dest_i) || (rs1_s == mem_dest_i));
    assign rs2_hit_s = use_rs2_s && (rs2_s != 5'd0) && ((rs2_s == exe_dest_i) || (rs2_s == mem_dest_i));
    assign hazard_s  = d_valid_r && (rs1_hit_s || rs2_hit_s);

    assign d_ready_s   = !hazard_s;
    assign d_allowin_s = !d_valid_r || (d_ready_s && e_allowin_i);
    assign d_valid_o   = d_valid_r && d_ready_s && !bj_taken_i;
    assign stall_fetch = !d_allowin_s && !bj_taken_i;

    assign d_to_e_bus[BUS_PC_LSB +: 32]      = d_pc_r;
    assign d_to_e_bus[BUS_IMM_LSB +: 32]     = imm_val_s;
    assign d_to_e_bus[BUS_RS1_LSB +: 32]     = rs1_data_s;
    assign d_to_e_bus[BUS_RS2_LSB +: 32]     = rs2_data_s;
    assign d_to_e_bus[BUS_RD_LSB +: 5]       = rd_s;
    assign d_to_e_bus[BUS_RD_WE]             = rd_we_s;
    assign d_to_e_bus[BUS_ALU_OP_LSB +: 4]   = alu_op_s;
    assign d_to_e_bus[BUS_SRC1_IS_PC]        = src1_is_pc_s;
    assign d_to_e_bus[BUS_SRC2_IS_IMM]       = src2_is_imm_s;
    assign d_to_e_bus[BUS_MEM_RE]            = mem_re_s;
    assign d_to_e_bus[BUS_MEM_WE]            = mem_we_s;
    assign d_to_e_bus[BUS_MEM_SIZE_LSB +: 2] = mem_size_s;
    assign d_to_e_bus[BUS_MEM_UNSIGNED]      = mem_unsigned_s;
    assign d_to_e_bus[BUS_BR_TYPE_LSB +: 3]  = br_type_s;
    assign d_to_e_bus[BUS_IS_JAL]            = is_jal_s;
    assign d_to_e_bus[BUS_IS_JALR]           = is_jalr_s;
    assign d_to_e_bus[BUS_ILLEGAL]           = illegal_s;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage: a cycle-by-cycle vector table plus a
// hand-written reset-during-stall sequence.
module tb_decode;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_valid_i;
    logic [63:0]  f_to_d_bus;
    logic         stall_fetch;
    logic         bj_taken_i;
    logic         e_allowin_i;
    logic [4:0]   exe_dest_i;
    logic [4:0]   mem_dest_i;
    logic         wb_we_i;
    logic [4:0]   wb_waddr_i;
    logic [31:0]  wb_wdata_i;
    logic         d_valid_o;
    logic [150:0] d_to_e_bus;

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    decode #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid_i (fetch_valid_i),
        .f_to_d_bus    (f_to_d_bus),
        .stall_fetch   (stall_fetch),
        .bj_taken_i    (bj_taken_i),
        .e_allowin_i   (e_allowin_i),
        .exe_dest_i    (exe_dest_i),
        .mem_dest_i    (mem_dest_i),
        .wb_we_i       (wb_we_i),
        .wb_waddr_i    (wb_waddr_i),
        .wb_wdata_i    (wb_wdata_i),
        .d_valid_o     (d_valid_o),
        .d_to_e_bus    (d_to_e_bus)
    );

    // Which bus fields a vector checks
    localparam logic [8:0] C_PC   = 9'h001;
    localparam logic [8:0] C_IMM  = 9'h002;
    localparam logic [8:0] C_RS1  = 9'h004;
    localparam logic [8:0] C_RD   = 9'h008;
    localparam logic [8:0] C_RDWE = 9'h010;
    localparam logic [8:0] C_ALU  = 9'h020;
    localparam logic [8:0] C_S2I  = 9'h040;
    localparam logic [8:0] C_ILL  = 9'h080;
    localparam logic [8:0] C_BR   = 9'h100;

    typedef struct {
        string       name;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        bj;
        logic        ea;
        logic [4:0]  ed;
        logic [4:0]  md;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_val;
        logic        e_stall;
        logic [8:0]  chk;
        logic [31:0] e_pc;
        logic [31:0] e_imm;
        logic [31:0] e_rs1;
        logic [4:0]  e_rd;
        logic        e_rdwe;
        logic [3:0]  e_alu;
        logic        e_s2i;
        logic        e_ill;
        logic [2:0]  e_br;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic bj, input logic ea, input logic [4:0] ed, input logic [4:0] md,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic e_val, input logic e_stall, input logic [8:0] chk,
                       input logic [31:0] e_pc, input logic [31:0] e_imm, input logic [31:0] e_rs1,
                       input logic [4:0] e_rd, input logic e_rdwe, input logic [3:0] e_alu,
                       input logic e_s2i, input logic e_ill, input logic [2:0] e_br);
        vec_t v;
        v.name = nm; v.fv = fv; v.pc = pc; v.inst = inst; v.bj = bj; v.ea = ea;
        v.ed = ed; v.md = md; v.we = we; v.wa = wa; v.wd = wd;
        v.e_val = e_val; v.e_stall = e_stall; v.chk = chk;
        v.e_pc = e_pc; v.e_imm = e_imm; v.e_rs1 = e_rs1; v.e_rd = e_rd;
        v.e_rdwe = e_rdwe; v.e_alu = e_alu; v.e_s2i = e_s2i; v.e_ill = e_ill; v.e_br = e_br;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, then check mid-low-phase
    task automatic apply(input vec_t v);
        @(negedge clk);
        fetch_valid_i = v.fv;
        f_to_d_bus    = {v.pc, v.inst};
        bj_taken_i    = v.bj;
        e_allowin_i   = v.ea;
        exe_dest_i    = v.ed;
        mem_dest_i    = v.md;
        wb_we_i       = v.we;
        wb_waddr_i    = v.wa;
        wb_wdata_i    = v.wd;
        #2;
        cmp({v.name, ".d_valid_o"}, {31'd0, d_valid_o}, {31'd0, v.e_val});
        cmp({v.name, ".stall_fetch"}, {31'd0, stall_fetch}, {31'd0, v.e_stall});
        if ((v.chk & C_PC) != 9'd0)   cmp({v.name, ".pc"}, d_to_e_bus[150:119], v.e_pc);
        if ((v.chk & C_IMM) != 9'd0)  cmp({v.name, ".imm"}, d_to_e_bus[118:87], v.e_imm);
        if ((v.chk & C_RS1) != 9'd0)  cmp({v.name, ".rs1_data"}, d_to_e_bus[86:55], v.e_rs1);
        if ((v.chk & C_RD) != 9'd0)   cmp({v.name, ".rd"}, {27'd0, d_to_e_bus[22:18]}, {27'd0, v.e_rd});
        if ((v.chk & C_RDWE) != 9'd0) cmp({v.name, ".rd_we"}, {31'd0, d_to_e_bus[17]}, {31'd0, v.e_rdwe});
        if ((v.chk & C_ALU) != 9'd0)  cmp({v.name, ".alu_op"}, {28'd0, d_to_e_bus[16:13]}, {28'd0, v.e_alu});
        if ((v.chk & C_S2I) != 9'd0)  cmp({v.name, ".src2_is_imm"}, {31'd0, d_to_e_bus[11]}, {31'd0, v.e_s2i});
        if ((v.chk & C_ILL) != 9'd0)  cmp({v.name, ".illegal"}, {31'd0, d_to_e_bus[0]}, {31'd0, v.e_ill});
        if ((v.chk & C_BR) != 9'd0)   cmp({v.name, ".br_type"}, {29'd0, d_to_e_bus[5:3]}, {29'd0, v.e_br});
    endtask

    initial begin
        reset         = 1'b1;
        fetch_valid_i = 1'b0;
        f_to_d_bus    = 64'd0;
        bj_taken_i    = 1'b0;
        e_allowin_i   = 1'b1;
        exe_dest_i    = 5'd0;
        mem_dest_i    = 5'd0;
        wb_we_i       = 1'b0;
        wb_waddr_i    = 5'd0;
        wb_wdata_i    = 32'd0;

        // Each row: inputs for one cycle, expected outputs in that same cycle
        //   name        fv   pc            inst          bj    ea    ed    md    we    wa    wd
        //   val   stall chk                                        pc  imm  rs1  rd  rdwe alu s2i ill br
        add("fill",      1'b1, 32'h00, 32'h00500093, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("addi",      1'b1, 32'h04, 32'h00208133, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_IMM|C_RS1|C_RD|C_RDWE|C_ALU|C_S2I|C_ILL|C_BR,
            32'h00, 32'd5, 32'd0, 5'd1, 1'b1, 4'd0, 1'b1, 1'b0, 3'd0);
        add("raw1",      1'b1, 32'h08, 32'h00018213, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b1, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("raw2",      1'b1, 32'h08, 32'h00018213, 1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b1, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("raw_issue", 1'b1, 32'h08, 32'h00018213, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_RS1|C_RD|C_RDWE|C_ALU|C_S2I|C_ILL,
            32'h04, 32'd0, 32'd0, 5'd2, 1'b1, 4'd0, 1'b0, 1'b0, 3'd0);
        add("wthru",     1'b0, 32'h0C, 32'h00000000, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF,
            1'b1, 1'b0, C_PC|C_IMM|C_RS1|C_RD|C_RDWE|C_ALU|C_S2I,
            32'h08, 32'd0, 32'hDEADBEEF, 5'd4, 1'b1, 4'd0, 1'b1, 1'b0, 3'd0);
        add("bubble",    1'b1, 32'h0C, 32'h00018213, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            add("bp",    1'b1, 32'h10, 32'hFE000EE3, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
                1'b1, 1'b1, C_PC|C_RS1|C_RD,
                32'h0C, 32'd0, 32'hDEADBEEF, 5'd4, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        end
        add("bp_issue",  1'b1, 32'h10, 32'hFE000EE3, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_RS1|C_RD,
            32'h0C, 32'd0, 32'hDEADBEEF, 5'd4, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("beq",       1'b1, 32'h14, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_IMM|C_RDWE|C_ILL|C_BR,
            32'h10, 32'hFFFFFFFC, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("illegal",   1'b1, 32'h18, 32'h00100013, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_RDWE|C_ILL,
            32'h14, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0);
        add("x0_dest",   1'b1, 32'h1C, 32'h00208133, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_IMM|C_RD|C_RDWE|C_ILL,
            32'h18, 32'd1, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("haz_mem",   1'b1, 32'h20, 32'h00500093, 1'b0, 1'b1, 5'd0, 5'd2, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b1, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("flush",     1'b1, 32'h20, 32'h00500093, 1'b1, 1'b1, 5'd0, 5'd2, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("post_flush",1'b1, 32'h24, 32'h407302B3, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);
        add("sub",       1'b1, 32'h28, 32'h4034D413, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_RD|C_RDWE|C_ALU|C_S2I|C_ILL,
            32'h24, 32'd0, 32'd0, 5'd5, 1'b1, 4'd1, 1'b0, 1'b0, 3'd0);
        add("srai",      1'b1, 32'h2C, 32'h12345537, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_RD|C_ALU|C_S2I|C_ILL,
            32'h28, 32'd0, 32'd0, 5'd8, 1'b0, 4'd7, 1'b1, 1'b0, 3'd0);
        add("lui",       1'b0, 32'h30, 32'h00000000, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b1, 1'b0, C_PC|C_IMM|C_RD|C_RDWE|C_ALU,
            32'h2C, 32'h12345000, 32'd0, 5'd10, 1'b1, 4'd10, 1'b0, 1'b0, 3'd0);
        add("idle",      1'b0, 32'h30, 32'h00000000, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0,
            1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        cmp("reset.d_valid_o", {31'd0, d_valid_o}, 32'd0);
        cmp("reset.stall_fetch", {31'd0, stall_fetch}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset arriving while decode is stalled on a RAW hazard
        @(negedge clk);
        fetch_valid_i = 1'b1;
        f_to_d_bus    = {32'h40, 32'h00208133};
        @(negedge clk);
        fetch_valid_i = 1'b0;
        exe_dest_i    = 5'd1;
        reset         = 1'b1;
        #2;
        cmp("rst_stall.stall_fetch", {31'd0, stall_fetch}, 32'd1);
        @(negedge clk);
        reset         = 1'b0;
        fetch_valid_i = 1'b1;
        f_to_d_bus    = {32'h44, 32'h00018213};
        #2;
        cmp("rst_after.d_valid_o", {31'd0, d_valid_o}, 32'd0);
        cmp("rst_after.stall_fetch", {31'd0, stall_fetch}, 32'd0);
        @(negedge clk);
        fetch_valid_i = 1'b0;
        exe_dest_i    = 5'd0;
        #2;
        cmp("rst_reload.d_valid_o", {31'd0, d_valid_o}, 32'd1);
        cmp("rst_reload.pc", d_to_e_bus[150:119], 32'h44);
        cmp("rst_reload.rs1_cleared", d_to_e_bus[86:55], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Second pipeline stage of the 5-stage RV32I core; sits directly downstream of fetch.
- Latches the fetch bus {pc, inst} into a decode register and decodes RV32I base instructions.
- Reads two operands from an internal register file and drives the decode-to-execute bus.
- Generates stall_fetch back to fetch for read-after-write interlock and downstream backpressure; squashes its contents on a taken branch/jump.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded into the decode register on reset; ignored while d_valid_o = 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_valid_i  in  1  fetch bus holds a valid instruction (fetch's current_valid_o)
- f_to_d_bus  in  `F_TO_D_BUS_WD (64)  {pc[63:32], inst[31:0]}
- stall_fetch  out  1  fetch must hold its pc this cycle
- bj_taken_i  in  1  execute resolved a taken branch/jump; flush
- e_allowin_i  in  1  execute can accept a new instruction this cycle
- exe_dest_i  in  5  rd of the valid register-writing instruction in execute, else 0
- mem_dest_i  in  5  same for the memory stage
- wb_we_i  in  1  writeback register write enable
- wb_waddr_i  in  5  writeback destination
- wb_wdata_i  in  32  writeback data
- d_valid_o  out  1  d_to_e_bus is valid and being issued this cycle
- d_to_e_bus  out  `D_TO_E_BUS_WD (151)  decoded instruction, layout below

Behaviour:
- Decode register: d_valid, d_pc, d_inst. On reset: d_valid = 0, d_pc = RESET_PC, d_inst = 0, all 32 registers = 0.
- Handshake:
  - d_ready = !hazard.
  - d_allowin = !d_valid || (d_ready && e_allowin_i).
  - d_valid_o = d_valid && d_ready && !bj_taken_i.
  - stall_fetch = !d_allowin && !bj_taken_i. A redirect is never blocked.
- Register update priority, each cycle:
  1. reset.
  2. bj_taken_i: d_valid <= 0; the fetch bus is discarded.
  3. d_allowin: d_valid <= fetch_valid_i, d_pc/d_inst <= f_to_d_bus.
  4. Otherwise hold.
- Latency: one cycle from fetch bus to d_to_e_bus.
- Hazard:
  - hazard = d_valid && ((use_rs1 && rs1 != 0 && (rs1 == exe_dest_i || rs1 == mem_dest_i)) || (use_rs2 && rs2 != 0 && (same for rs2))).
  - There is no forwarding from execute or memory.
  - Writeback is covered by regfile write-through.
- Register usage:
  - use_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - use_rs2: BRANCH, STORE, OP.
- Register file:
  - 32x32, 2 async read ports, 1 sync write port.
  - x0 reads 0; writes to x0 are ignored.
  - Same-cycle write/read of the same nonzero address returns wb_wdata_i (write-through).
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits. B and J immediates have bit 0 = 0.
- Decode:
  - Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - MISC-MEM (FENCE) decodes as a NOP: rd_we = 0, no memory access.
  - Any other opcode, or an invalid funct3/funct7 combination: illegal = 1, rd_we = 0, mem_re = mem_we = 0.
  - rd_we = 0 whenever rd = 0.
- d_to_e_bus layout:
  - [150:119] pc; [118:87] imm; [86:55] rs1_data; [54:23] rs2_data
  - [22:18] rd; [17] rd_we; [16:13] alu_op; [12] src1_is_pc; [11] src2_is_imm
  - [10] mem_re; [9] mem_we; [8:7] mem_size (0 = B, 1 = H, 2 = W); [6] mem_unsigned
  - [5:3] br_type (funct3 for BRANCH, else 0); [2] is_jal; [1] is_jalr; [0] illegal
- Bus contents are don't-care when d_valid_o = 0.
- alu_op mapping:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, LUI(pass src2)=10.
  - LOAD, STORE, AUIPC, JAL and JALR use ADD.
- Simultaneous events:
  - bj_taken_i together with hazard: flush wins, and stall_fetch = 0.
  - Reset mid-stall: all state cleared on the next edge.

Decomposition:
- cpu_defs.vh holds:
  - `D_TO_E_BUS_WD (151) and its field offsets.
  - Opcode constants.
  - ALU_OP_* codes.
  - MEM_SIZE_* codes.
- One sub-module: regfile (32x32, x0 hardwired, write-through).
- Immediate and control decode stay combinational inside decode.

Test Plan:
- Reset, then pc 0x0 with inst 0x00500093 (addi x1,x0,5) → next cycle:
  - d_valid_o = 1, rd = 1, rd_we = 1, imm = 5, alu_op = ADD, src2_is_imm = 1, rs1_data = 0.
- Load-use interlock: inst 0x00208133 (add x2,x1,x2) with exe_dest_i = 1 for 2 cycles →
  - stall_fetch = 1 and d_valid_o = 0 for those cycles.
  - Issues on the third cycle with unchanged pc.
- Flush: bj_taken_i = 1 while d_valid = 1 and hazard asserted →
  - stall_fetch = 0.
  - d_valid_o = 0 that cycle and the next.
- Write-through: wb_we_i = 1, wb_waddr_i = 3, wb_wdata_i = 0xDEADBEEF in the same cycle decode holds inst 0x00018213 (addi x4,x3,0) → rs1_data = 0xDEADBEEF.
- Backpressure: e_allowin_i = 0 for 3 cycles with a valid instruction held →
  - stall_fetch = 1.
  - d_pc/d_inst unchanged.
  - Instruction issues when e_allowin_i returns to 1.
- Decode sweep:
  - beq x0,x0,-4 (0xFE000EE3) → br_type = 0, imm = 0xFFFFFFFC.
  - inst 0xFFFFFFFF → illegal = 1, rd_we = 0.
  - x0 destination (0x00100013) → rd_we = 0.
